// File: rtl/permute_issue_ctrl.sv
// permute_issue_ctrl: issue controller for the Permute (odd) pipe.
// Accepts decoded instrs by valid/ready, holds them on RAW/WAW hazards using a
// per-register pending scoreboard, caps in-flight writers at MAX_INFLIGHT, and
// registers the Permute RF/FWD-stage inputs one cycle after issue.
// Optional feature macro: PERMUTE_ISSUE_FWD_EN (writeback-cycle forwarding).
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   in_valid/in_ready                   decoded instr handshake (in_ready comb.)
//   in_op/format/imm/rt/ra/rb_addr      decoded instr fields
//   in_uses_ra/rb, in_reg_write         source use and destination write flags
//   flush                               squash the presented instr this cycle
//   reg_write_wb/rt_addr_wb             Permute writeback, releases pending entry
//   op/format/imm/rt_addr/reg_write     Permute stage inputs, op=0 is a nop
//   ra_addr/rb_addr                     RF read addresses, registered with op
//   fwd_ra/fwd_rb                       RF stage takes previous-cycle wb data
//   inflight                            in-flight writer count
//   stall_cnt                           saturating count of hazard/cap stalls
module permute_issue_ctrl #(
  parameter int NUM_REGS     = 128,
  parameter int ADDR_W       = 7,
  parameter int MAX_INFLIGHT = 4,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:10]       in_op,
  input  logic [2:0]        in_format,
  input  logic [0:17]       in_imm,
  input  logic [0:ADDR_W-1] in_rt_addr,
  input  logic [0:ADDR_W-1] in_ra_addr,
  input  logic [0:ADDR_W-1] in_rb_addr,
  input  logic              in_uses_ra,
  input  logic              in_uses_rb,
  input  logic              in_reg_write,
  input  logic              flush,
  input  logic              reg_write_wb,
  input  logic [0:ADDR_W-1] rt_addr_wb,
  output logic [0:10]       op,
  output logic [2:0]        format,
  output logic [0:17]       imm,
  output logic [0:ADDR_W-1] rt_addr,
  output logic              reg_write,
  output logic [0:ADDR_W-1] ra_addr,
  output logic [0:ADDR_W-1] rb_addr,
  output logic              fwd_ra,
  output logic              fwd_rb,
  output logic [2:0]        inflight,
  output logic [CNT_W-1:0]  stall_cnt
);
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [2:0]          inflight_q, inflight_d, infl_eff;
  logic                wb_ok, m_ra, m_rb, m_rt, hazard, issue, wr_issue;
  // A writeback only counts if it releases a real pending writer; stray or
  // post-reset writebacks are ignored so the counter can never underflow.
  assign wb_ok = reg_write_wb & pending_q[rt_addr_wb] & (inflight_q != 3'd0);
`ifdef PERMUTE_ISSUE_FWD_EN
  // The entry being written back this cycle no longer blocks; its data is
  // forwarded to the RF stage next cycle.
  assign m_ra     = wb_ok & (rt_addr_wb == in_ra_addr);
  assign m_rb     = wb_ok & (rt_addr_wb == in_rb_addr);
  assign m_rt     = wb_ok & (rt_addr_wb == in_rt_addr);
  assign infl_eff = inflight_q - {2'b0, wb_ok};
`else
  assign m_ra     = 1'b0;
  assign m_rb     = 1'b0;
  assign m_rt     = 1'b0;
  assign infl_eff = inflight_q;
`endif
  assign hazard = (in_uses_ra & pending_q[in_ra_addr] & ~m_ra) |
                  (in_uses_rb & pending_q[in_rb_addr] & ~m_rb) |
                  (in_reg_write & pending_q[in_rt_addr] & ~m_rt);
  assign in_ready   = ~flush & ~hazard & ~(in_reg_write & (infl_eff == 3'(MAX_INFLIGHT)));
  assign issue      = in_valid & in_ready;
  assign wr_issue   = issue & in_reg_write;
  // Clear before set so a same-index set wins.
  assign pending_d  = (pending_q & ~(NUM_REGS'(wb_ok) << rt_addr_wb)) |
                      (NUM_REGS'(wr_issue) << in_rt_addr);
  assign inflight_d = inflight_q + {2'b0, wr_issue} - {2'b0, wb_ok};
  assign inflight   = inflight_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= '0;
      inflight_q <= '0;
      stall_cnt  <= '0;
      op         <= '0;
      format     <= '0;
      imm        <= '0;
      rt_addr    <= '0;
      reg_write  <= 1'b0;
      ra_addr    <= '0;
      rb_addr    <= '0;
      fwd_ra     <= 1'b0;
      fwd_rb     <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      inflight_q <= inflight_d;
      if (in_valid & ~in_ready & ~flush & ~&stall_cnt)
        stall_cnt <= stall_cnt + CNT_W'(1);
      op        <= issue ? in_op : '0;
      reg_write <= wr_issue;
      fwd_ra    <= issue & in_uses_ra & m_ra;
      fwd_rb    <= issue & in_uses_rb & m_rb;
      if (issue) begin
        format  <= in_format;
        imm     <= in_imm;
        rt_addr <= in_rt_addr;
        ra_addr <= in_ra_addr;
        rb_addr <= in_rb_addr;
      end
    end
  end
endmodule

// File: tb/tb_permute_issue_ctrl.sv
// tb_permute_issue_ctrl: scoreboard bench for the Permute issue controller.
module tb_permute_issue_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [0:10] in_op = '0;
  logic [2:0]  in_format = '0;
  logic [0:17] in_imm = '0;
  logic [0:6]  in_rt_addr = '0, in_ra_addr = '0, in_rb_addr = '0;
  logic        in_uses_ra = 1'b0, in_uses_rb = 1'b0, in_reg_write = 1'b0;
  logic        flush = 1'b0, reg_write_wb = 1'b0;
  logic [0:6]  rt_addr_wb = '0;
  logic [0:10] op;
  logic [2:0]  format;
  logic [0:17] imm;
  logic [0:6]  rt_addr, ra_addr, rb_addr;
  logic        reg_write, fwd_ra, fwd_rb;
  logic [2:0]  inflight;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic [0:10] op;
    logic [2:0]  fmt;
    logic [0:17] imm;
    logic [0:6]  rt, ra, rb;
    logic        rw;
  } exp_t;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0, exp_stall = 0;

  permute_issue_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_format(in_format), .in_imm(in_imm),
    .in_rt_addr(in_rt_addr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
    .in_uses_ra(in_uses_ra), .in_uses_rb(in_uses_rb), .in_reg_write(in_reg_write),
    .flush(flush), .reg_write_wb(reg_write_wb), .rt_addr_wb(rt_addr_wb),
    .op(op), .format(format), .imm(imm), .rt_addr(rt_addr), .reg_write(reg_write),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .fwd_ra(fwd_ra), .fwd_rb(fwd_rb),
    .inflight(inflight), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  task automatic present(input logic [0:10] o, input logic [2:0] f, input logic [0:17] im,
                         input logic [0:6] rt, input logic [0:6] ra, input logic [0:6] rb,
                         input logic ura, input logic urb, input logic rw);
    in_valid = 1'b1; in_op = o; in_format = f; in_imm = im;
    in_rt_addr = rt; in_ra_addr = ra; in_rb_addr = rb;
    in_uses_ra = ura; in_uses_rb = urb; in_reg_write = rw;
    sb.push_back('{op: o, fmt: f, imm: im, rt: rt, ra: ra, rb: rb, rw: rw});
  endtask

  task automatic expect_ready(input string tag, input logic e);
    #1;
    chk(tag, in_ready, e);
    if (!e && in_valid && !flush) exp_stall++;
  endtask

  task automatic wb(input logic [0:6] a);
    reg_write_wb = 1'b1;
    rt_addr_wb = a;
  endtask

  // Every nonzero op out of the DUT must match the oldest presented instr.
  always @(posedge clk) begin
    #2;
    if (op != '0) begin
      if (sb.size() == 0) chk("sb_unexpected_op", op, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_op", op, e.op);
        chk("out_fmt", format, e.fmt);
        chk("out_imm", imm, e.imm);
        chk("out_rt", rt_addr, e.rt);
        chk("out_ra", ra_addr, e.ra);
        chk("out_rb", rb_addr, e.rb);
        chk("out_rw", reg_write, e.rw);
      end
    end
  end

  initial begin
    // 1: reset held with a valid instr presented
    in_valid = 1'b1; in_op = 11'h055; in_reg_write = 1'b1; in_rt_addr = 7'd1;
    nxt; nxt;
    chk("rst_op", op, 0);
    chk("rst_rw", reg_write, 0);
    chk("rst_inflight", inflight, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0; in_valid = 1'b0;
    nxt;
    chk("rst_op_idle", op, 0);

    // 2: RAW, shlh rt=3 then gbb ra=3
    present(11'h05a, 3'd1, 18'h00011, 7'd3, 7'd1, 7'd2, 1, 1, 1);
    expect_ready("raw_first", 1);
    nxt;
    present(11'h1b0, 3'd2, 18'h00000, 7'd4, 7'd3, 7'd0, 1, 0, 1);
    expect_ready("raw_stall0", 0);
    chk("raw_inflight", inflight, 1);
    nxt; expect_ready("raw_stall1", 0);
    nxt; expect_ready("raw_stall2", 0);
    nxt; wb(7'd3);
`ifdef PERMUTE_ISSUE_FWD_EN
    expect_ready("raw_wbcyc", 1);
    nxt; reg_write_wb = 1'b0; in_valid = 1'b0;
    #1 chk("raw_fwd_ra", fwd_ra, 1);
`else
    expect_ready("raw_wbcyc", 0);
    nxt; reg_write_wb = 1'b0;
    expect_ready("raw_after_wb", 1);
    nxt; in_valid = 1'b0;
    #1 chk("raw_fwd_ra", fwd_ra, 0);
`endif
    chk("raw_stall_cnt", stall_cnt, exp_stall);
    nxt;
    chk("raw_inflight2", inflight, 1);
    wb(7'd4);
    nxt; reg_write_wb = 1'b0;
    #1 chk("raw_inflight3", inflight, 0);

    // 3: in-flight cap
    for (int i = 0; i < 5; i++) begin
      present(11'h100 + 11'(i), 3'd3, 18'(i), 7'(5 + i), 7'd0, 7'd0, 0, 0, 1);
      expect_ready($sformatf("cap_w%0d", i), i < 4);
      if (i < 4) nxt;
    end
    chk("cap_inflight", inflight, 4);
    nxt; expect_ready("cap_hold", 0);
    nxt; wb(7'd5);
`ifdef PERMUTE_ISSUE_FWD_EN
    expect_ready("cap_wbcyc", 1);
    nxt; reg_write_wb = 1'b0; in_valid = 1'b0;
`else
    expect_ready("cap_wbcyc", 0);
    nxt; reg_write_wb = 1'b0;
    expect_ready("cap_after_wb", 1);
    nxt; in_valid = 1'b0;
`endif
    #1 chk("cap_inflight2", inflight, 4);
    chk("cap_stall_cnt", stall_cnt, exp_stall);
    for (int a = 6; a < 10; a++) begin
      wb(7'(a));
      nxt;
    end
    reg_write_wb = 1'b0;
    #1 chk("cap_drain", inflight, 0);

    // 4: WAW on rt=6
    nxt;
    present(11'h03c, 3'd4, 18'h2abcd, 7'd6, 7'd10, 7'd0, 1, 0, 1);
    expect_ready("waw_first", 1);
    nxt;
    present(11'h0f1, 3'd5, 18'h00123, 7'd6, 7'd11, 7'd12, 1, 1, 1);
    expect_ready("waw_stall0", 0);
    nxt; expect_ready("waw_stall1", 0);
    nxt; wb(7'd6);
`ifdef PERMUTE_ISSUE_FWD_EN
    expect_ready("waw_wbcyc", 1);
    nxt; reg_write_wb = 1'b0; in_valid = 1'b0;
`else
    expect_ready("waw_wbcyc", 0);
    nxt; reg_write_wb = 1'b0;
    expect_ready("waw_after_wb", 1);
    nxt; in_valid = 1'b0;
`endif
    nxt; wb(7'd6);
    nxt; reg_write_wb = 1'b0;
    #1 chk("waw_inflight", inflight, 0);
    chk("waw_stall_cnt", stall_cnt, exp_stall);

    // 5: flush squashes an otherwise-ready instr
    nxt;
    in_valid = 1'b1; flush = 1'b1; in_op = 11'h077; in_rt_addr = 7'd20;
    in_reg_write = 1'b1; in_uses_ra = 1'b0; in_uses_rb = 1'b0;
    #1 chk("flush_ready", in_ready, 0);
    nxt; flush = 1'b0; in_valid = 1'b0;
    #1 chk("flush_op", op, 0);
    chk("flush_rw", reg_write, 0);
    chk("flush_rt_hold", rt_addr, 6);
    chk("flush_ra_hold", ra_addr, 11);
    chk("flush_stall_cnt", stall_cnt, exp_stall);
    chk("flush_inflight", inflight, 0);
    present(11'h0aa, 3'd6, 18'h3ffff, 7'd21, 7'd20, 7'd20, 1, 1, 0);
    expect_ready("flush_no_pending", 1);
    nxt; in_valid = 1'b0;

    // 6: reset with writers in flight, then a late writeback
    for (int i = 0; i < 3; i++) begin
      present(11'h200 + 11'(i), 3'd7, 18'(i), 7'(30 + i), 7'd0, 7'd0, 0, 0, 1);
      expect_ready($sformatf("rst6_w%0d", i), 1);
      nxt;
    end
    in_valid = 1'b0;
    #1 chk("rst6_inflight", inflight, 3);
    reset = 1'b1;
    nxt; reset = 1'b0;
    #1 chk("rst6_inflight0", inflight, 0);
    chk("rst6_op", op, 0);
    chk("rst6_stall", stall_cnt, 0);
    exp_stall = 0;
    wb(7'd30);
    nxt; reg_write_wb = 1'b0;
    #1 chk("rst6_no_underflow", inflight, 0);
    present(11'h2f0, 3'd1, 18'h00042, 7'd33, 7'd31, 7'd32, 1, 1, 1);
    expect_ready("rst6_pending_clr", 1);
    nxt; in_valid = 1'b0;
    #1 chk("rst6_inflight1", inflight, 1);
    chk("rst6_stall_cnt", stall_cnt, exp_stall);

    nxt; nxt;
    chk("sb_drain", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
